// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and memory-side bus of the data memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [2:0]            funct3_0, funct3_1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  err0, err1;
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req0, req1, we0, we1, funct3_0, funct3_1, addr0, addr1, wdata0, wdata1,
    input  mem_rd_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    output mem_wr_en, mem_funct3, mem_addr, mem_wr_data
  );

  modport master (
    output req0, req1, we0, we1, funct3_0, funct3_1, addr0, addr1, wdata0, wdata1,
    output mem_rd_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    input  mem_wr_en, mem_funct3, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and access sequencer for the data memory
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_SIZE * 4);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  gnt0, gnt1;

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [ADDR_WIDTH-1:0] addr);
    logic bad_f3;
    logic misaligned;
    if (we) bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
    else    bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ||
                 ((f3 == 3'b010) && (addr[1:0] != 2'b00));
    return bad_f3 || misaligned || (addr >= MEM_BYTES);
  endfunction

  // last_q == 1 means port 1 was granted last, so port 0 wins the next tie
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (bus.req0 && (!bus.req1 || last_q)) gnt0 = 1'b1;
          else if (bus.req1)                     gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          state_d  = ACCESS;
          last_d   = gnt1;
          port_d   = gnt1;
          we_d     = gnt1 ? bus.we1      : bus.we0;
          funct3_d = gnt1 ? bus.funct3_1 : bus.funct3_0;
          addr_d   = gnt1 ? bus.addr1    : bus.addr0;
          wdata_d  = gnt1 ? bus.wdata1   : bus.wdata0;
          err_d    = access_err(we_d, funct3_d, addr_d);
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_data = (state_q == ACCESS && !we_q && !err_q) ? bus.mem_rd_data : '0;
    rvalid0_d = (state_q == ACCESS) && !port_q;
    rvalid1_d = (state_q == ACCESS) &&  port_q;
    err0_d    = rvalid0_d && err_q;
    err1_d    = rvalid1_d && err_q;
    rdata0_d  = rvalid0_d ? load_data : '0;
    rdata1_d  = rvalid1_d ? load_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      port_q    <= port_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Write enable decodes straight from state so reset kills it without waiting for an edge
  assign bus.mem_wr_en   = (state_q == ACCESS) && we_q && !err_q;
  assign bus.mem_funct3  = funct3_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wdata_q;
  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.rvalid0     = rvalid0_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.err0        = err0_q;
  assign bus.err1        = err1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t q0[$];
  resp_t q1[$];
  int    checks = 0;
  int    failures = 0;
  int    wr_count = 0;
  int    rv0_count = 0;
  int    rv1_count = 0;
  int    due0 = 0;
  int    due1 = 0;
  logic  prev_gnt = 1'b0;

  // memory model: combinational read with load extension, byte/half/word write
  logic [31:0] mem [MS];
  logic        init_done = 1'b0;
  logic [31:0] rd_model;

  always_comb begin : rd_blk
    logic [31:0] w;
    logic [31:0] s;
    w = mem[bus.mem_addr[7:2]];
    s = w >> {bus.mem_addr[1:0], 3'b000};
    case (bus.mem_funct3)
      3'b000:  rd_model = {{24{s[7]}}, s[7:0]};
      3'b100:  rd_model = {24'h0, s[7:0]};
      3'b001:  rd_model = {{16{s[15]}}, s[15:0]};
      3'b101:  rd_model = {16'h0, s[15:0]};
      default: rd_model = w;
    endcase
  end
  assign bus.mem_rd_data = rd_model;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < MS; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      init_done <= 1'b1;
    end else if (bus.mem_wr_en) begin
      case (bus.mem_funct3)
        3'b000: mem[bus.mem_addr[7:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wr_data[7:0];
        3'b001: mem[bus.mem_addr[7:2]][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_wr_data[15:0];
        default: mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // response monitor: checks rvalid timing, exclusivity and pops the scoreboard
  always @(negedge clk) begin : mon
    resp_t r;
    if (!rst_n) begin
      due0 = 0;
      due1 = 0;
      q0.delete();
      q1.delete();
      prev_gnt = 1'b0;
    end else begin
      if (bus.mem_wr_en) wr_count++;
      if (bus.rvalid0 || bus.rvalid1) check("rv_exclusive", 32'(bus.rvalid0 & bus.rvalid1), 32'd0);
      if (bus.rvalid0 || due0 == 1) begin
        check("rv0_timing", 32'(bus.rvalid0), 32'(due0 == 1));
        if (bus.rvalid0) begin
          rv0_count++;
          if (q0.size() == 0) check("rv0_unexpected", 32'd1, 32'd0);
          else begin
            r = q0.pop_front();
            check("rdata0", bus.rdata0, r.rdata);
            check("err0", 32'(bus.err0), 32'(r.err));
          end
        end
      end
      if (bus.rvalid1 || due1 == 1) begin
        check("rv1_timing", 32'(bus.rvalid1), 32'(due1 == 1));
        if (bus.rvalid1) begin
          rv1_count++;
          if (q1.size() == 0) check("rv1_unexpected", 32'd1, 32'd0);
          else begin
            r = q1.pop_front();
            check("rdata1", bus.rdata1, r.rdata);
            check("err1", 32'(bus.err1), 32'(r.err));
          end
        end
      end
      if (bus.gnt0 || bus.gnt1) check("gnt_in_access", 32'(prev_gnt), 32'd0);
      prev_gnt = bus.gnt0 | bus.gnt1;
      if (due0 > 0) due0--;
      if (due1 > 0) due1--;
      if (bus.gnt0) due0 = 2;
      if (bus.gnt1) due1 = 2;
    end
  end

  task automatic push_exp(input int port, input logic [31:0] rd, input logic e);
    resp_t r;
    r.rdata = rd;
    r.err   = e;
    if (port == 0) q0.push_back(r);
    else           q1.push_back(r);
  endtask

  task automatic drive(input int port, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.we0 = we; bus.funct3_0 = f3; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.funct3_1 = f3; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end
  endtask

  // called at posedge+1; returns at posedge+1 of the ACCESS cycle with req dropped
  task automatic do_req(input int port, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    logic got;
    push_exp(port, exp_rd, exp_err);
    drive(port, we, f3, addr, wdata);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((port == 0) ? bus.gnt0 : bus.gnt1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("gnt_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (port == 0) bus.req0 = 1'b0;
    else           bus.req1 = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && due0 == 0 && due1 == 0) break;
    end
    check("drain", 32'(q0.size() + q1.size() + due0 + due1), 32'd0);
  endtask

  initial begin : stim
    int  w0;
    int  r0;
    int  r1;
    logic got;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.funct3_0 = 0; bus.funct3_1 = 0; bus.addr0 = 0; bus.addr1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    check("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}), 32'd0);
    check("rst_rdata", bus.rdata0 | bus.rdata1, 32'd0);
    check("rst_mem", 32'(bus.mem_wr_en) | bus.mem_addr | bus.mem_wr_data | 32'(bus.mem_funct3), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // store then load on port 0
    w0 = wr_count;
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    wait_done();
    check("t1_wr_pulses", 32'(wr_count - w0), 32'd1);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_done();

    // sub-word loads on port 1
    do_req(1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    wait_done();
    do_req(1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    wait_done();
    do_req(1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    wait_done();
    do_req(1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    wait_done();

    // illegal accesses on port 0
    w0 = wr_count;
    do_req(0, 1'b1, 3'b010, 32'h06, 32'hFFFFFFFF, 32'h0, 1'b1);
    wait_done();
    do_req(0, 1'b0, 3'b001, 32'h03, 32'h0, 32'h0, 1'b1);
    wait_done();
    do_req(0, 1'b1, 3'b000, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    wait_done();
    do_req(0, 1'b0, 3'b011, 32'h04, 32'h0, 32'h0, 1'b1);
    wait_done();
    check("t4_no_write", 32'(wr_count - w0), 32'd0);
    do_req(0, 1'b0, 3'b010, 32'h04, 32'h0, 32'hA5000001, 1'b0);
    wait_done();

    // both ports requesting continuously from reset
    rst_n = 1'b0;
    drive(0, 1'b1, 3'b010, 32'h20, 32'h11110000);
    drive(1, 1'b1, 3'b010, 32'h24, 32'h22220001);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = wr_count;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        #1;
        if (bus.gnt0 || bus.gnt1) begin
          got = 1'b1;
          check("t3_order", 32'(bus.gnt1), 32'(k % 2));
          push_exp(bus.gnt1 ? 1 : 0, 32'h0, 1'b0);
        end
        @(posedge clk); #1;
      end
      check("t3_gnt_wait", 32'(got), 32'd1);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_done();
    check("t3_wr_pulses", 32'(wr_count - w0), 32'd4);
    check("t3_mem20", mem[8], 32'h11110000);
    check("t3_mem24", mem[9], 32'h22220001);

    // reset during a store ACCESS
    r1 = rv1_count;
    do_req(1, 1'b1, 3'b010, 32'h08, 32'h12345678, 32'h0, 1'b0);
    check("t5_wr_en_access", 32'(bus.mem_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_wr_en_reset", 32'(bus.mem_wr_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_rvalid", 32'(rv1_count - r1), 32'd0);
    do_req(1, 1'b0, 3'b010, 32'h08, 32'h0, 32'hA5000002, 1'b0);
    wait_done();

    // withdrawal: port 0 drops req in the cycle port 1 is granted
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_done();
    r0 = rv0_count;
    push_exp(1, 32'h22220001, 1'b0);
    drive(0, 1'b0, 3'b010, 32'h04, 32'h0);
    drive(1, 1'b0, 3'b010, 32'h24, 32'h0);
    #1;
    check("t6_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b01);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_rv0", 32'(rv0_count - r0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data memory (combinational read, synchronous byte/half/word write).
- Port 0 is the CPU load/store unit; port 1 is the program loader/debug DMA.
- The block accepts one request at a time under round-robin arbitration.
- It rejects misaligned, illegal or out-of-range accesses without touching memory.
- It returns load data with a registered one-cycle valid pulse.

Parameters:
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, data width
MEM_SIZE, 64, memory depth in words; legal byte addresses are 0 .. MEM_SIZE*4-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req0, req1  in  1  request valid, per port
we0, we1  in  1  1=store, 0=load
funct3_0, funct3_1  in  3  RISC-V load/store funct3
addr0, addr1  in  ADDR_WIDTH  byte address
wdata0, wdata1  in  DATA_WIDTH  store data
gnt0, gnt1  out  1  request accepted this cycle
rvalid0, rvalid1  out  1  response pulse
rdata0, rdata1  out  DATA_WIDTH  load data; 0 for stores and errors
err0, err1  out  1  error flag, qualified by rvalid
mem_wr_en  out  1  to memory write enable
mem_funct3  out  3  to memory funct3
mem_addr  out  ADDR_WIDTH  to memory address
mem_wr_data  out  DATA_WIDTH  to memory write data
mem_rd_data  in  DATA_WIDTH  from memory combinational read data

Behaviour:
Reset values:
- All outputs 0; state IDLE; last-grant pointer = 1, so port 0 wins the first tie.
- Latched request registers 0.

States: IDLE, ACCESS.

IDLE:
- gnt is combinational from req.
- Single requester wins.
- Both requesting: the port not equal to last-grant wins.
- On the grant edge the block latches we/funct3/addr/wdata, updates last-grant, computes err, and moves to ACCESS.
- No req: stay in IDLE.
- Requesters hold fields stable while req=1 and gnt=0; deasserting req before gnt is a legal withdrawal.

ACCESS (exactly 1 cycle):
- mem_funct3/addr/wr_data driven from the latched registers.
- mem_wr_en = latched we AND NOT err.
- rdata register <= (load AND NOT err) ? mem_rd_data : 0.
- Next state is always IDLE; no gnt is issued in ACCESS.

Response:
- rvalid/err/rdata of the granted port are registered and valid in the cycle after ACCESS; rvalid is a 1-cycle pulse.
- A new grant may occur in that same cycle.
- Non-granted port's rdata holds 0; its rvalid and err stay 0.
- Latency: gnt edge -> rvalid = 2 cycles. Peak throughput: 1 access per 2 cycles.

Outside ACCESS:
- mem_wr_en = 0.
- Other mem_* hold their last latched values.

err conditions:
- Loads: funct3 not in {000,001,010,100,101}. Stores: funct3 not in {000,001,010}.
- Halfword (001/101) with addr[0]=1; word (010) with addr[1:0]!=0.
- addr >= MEM_SIZE*4.
- Errored accesses still spend the ACCESS cycle: memory unchanged, rdata=0, err=1.

Reset mid-operation:
- rst_n low forces IDLE and mem_wr_en=0 immediately; no write occurs at an edge while reset is asserted.
- Pending responses are dropped (rvalid stays 0).

Fairness: with both ports requesting continuously, grants alternate 0,1,0,1.

Test Plan:
1. Port0 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> gnt0 once per request; mem_wr_en high exactly 1 cycle; LW rvalid0 2 cycles after gnt, rdata0=0xDEADBEEF, err0=0.
2. After case 1, port1 LB 0x13 -> rdata1=0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
3. req0 and req1 held high from reset, port0 stores to 0x20, port1 stores to 0x24 -> grant order 0,1,0,1; one mem_wr_en pulse per grant; no grant during ACCESS; rvalid0 and rvalid1 never assert together.
4. Port0 SW 0x06, LH 0x03, SB 0x100 (MEM_SIZE=64), load funct3=011 -> each returns err0=1, rdata0=0, mem_wr_en never asserted; memory word 0x04 unchanged on readback.
5. Port1 SW 0x08 data 0x12345678 with rst_n dropped during ACCESS -> mem_wr_en falls immediately, no rvalid1; after reset, LW 0x08 returns the prior contents.
6. req0 asserted then withdrawn in the same cycle req1 is granted -> port0 receives no gnt0 and no rvalid0; port1 completes normally.
